// File: rtl/snappy_ctrl_pkg.sv
// Shared constants for the page-level decompressor control blocks.
// Holds the dispatcher state encoding and the BRAM write-queue bank count.
// No logic; imported by token_dispatch, its interface users and rr_arbiter users.
package snappy_ctrl_pkg;

  // Dispatcher states, kept as plain 2-bit constants so older blocks that
  // compare against raw codes keep working.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int                   RAM_BANKS  = 16;
  localparam logic [RAM_BANKS-1:0] RAM_ALLONE = 16'hffff;

endpackage

// File: rtl/token_dispatch_if.sv
// Token FIFO read side plus the parser-array broadcast bus.
// master: the dispatcher (pops tf_*, drives ps_valid/ps_data).
// slave: the FIFO + parser array side (drives tf_empty/tf_dout, ps_ready/ps_empty).
interface token_dispatch_if #(
  parameter int NUM_PARSER = 6,
  parameter int TOKEN_W    = 144
);
  logic                  tf_empty;
  logic [TOKEN_W-1:0]    tf_dout;
  logic                  tf_rd_en;
  logic [NUM_PARSER-1:0] ps_ready;
  logic [NUM_PARSER-1:0] ps_empty;
  logic [NUM_PARSER-1:0] ps_valid;
  logic [TOKEN_W-1:0]    ps_data;

  modport master (
    input  tf_empty, tf_dout, ps_ready, ps_empty,
    output tf_rd_en, ps_valid, ps_data
  );

  modport slave (
    output tf_empty, tf_dout, ps_ready, ps_empty,
    input  tf_rd_en, ps_valid, ps_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit scanning ptr, ptr+1, ... modulo N.
// Latency: purely combinational.
// Backpressure: none; any=0 when no requester, grant outputs are then zero.
// Ports: req (requests), ptr (scan start), gnt_onehot/gnt_idx (winner), any.
module rr_arbiter #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    logic [IW-1:0] j;
    j          = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt_onehot    = '0;
        gnt_onehot[j] = 1'b1;
        gnt_idx       = j;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/token_dispatch.sv
// Pops the token FIFO and hands each token to an idle parser (round robin); tracks page drain.
// Latency: 1 cycle FIFO head -> ps_valid; up to one token per cycle with >=2 parsers ready.
// Backpressure: no pop while FIFO empty or no parser eligible; ps_data holds between tokens.
// Ports: clk/rst, start/page_input_finish/cl_finish page control, tf_ps bus (FIFO + parsers),
// ram_empty, page_finish/busy/tok_count status. DISPATCH_STATS_EN adds ps_tok_cnt, stall_cnt.
module token_dispatch
  import snappy_ctrl_pkg::*;
#(
  parameter int NUM_PARSER = 6,
  parameter int TOKEN_W    = 144,
  parameter int DRAIN_CYC  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    page_input_finish,
  token_dispatch_if.master        tf_ps,
  input  logic [RAM_BANKS-1:0]    ram_empty,
  input  logic                    cl_finish,
  output logic                    page_finish,
  output logic                    busy,
  output logic [CNT_W-1:0]        tok_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [NUM_PARSER*16-1:0] ps_tok_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(NUM_PARSER);

  logic [1:0]            state;
  logic [PW-1:0]         rr_ptr;
  logic                  in_done;
  logic [7:0]            drain_cnt;
  logic [NUM_PARSER-1:0] ps_valid_q;
  logic [TOKEN_W-1:0]    ps_data_q;
  logic [NUM_PARSER-1:0] elig;
  logic [NUM_PARSER-1:0] gnt_onehot;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic                  dispatch_en;
  logic                  fire;
  logic                  in_done_nxt;
  logic                  all_quiet;

  // A parser's ready only drops a cycle after it takes a token, so the one
  // strobed this cycle must not be picked again.
  assign elig = tf_ps.ps_ready & ~ps_valid_q;

  rr_arbiter #(.N(NUM_PARSER), .IW(PW)) u_arb (
    .req        (elig),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // DRAIN keeps dispatching so a straggler token still reaches a parser.
  assign dispatch_en    = (state == RUN) || (state == DRAIN);
  assign fire           = dispatch_en && !tf_ps.tf_empty && gnt_any && !rst;
  assign tf_ps.tf_rd_en = fire;
  assign tf_ps.ps_valid = ps_valid_q;
  assign tf_ps.ps_data  = ps_data_q;

  assign in_done_nxt = in_done | page_input_finish;
  assign all_quiet   = (&tf_ps.ps_empty) && (ram_empty == RAM_ALLONE) &&
                       tf_ps.tf_empty && (ps_valid_q == '0);

  assign page_finish = (state == DONE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_valid_q <= '0;
      ps_data_q  <= '0;
      rr_ptr     <= '0;
      tok_count  <= '0;
    end else begin
      ps_valid_q <= fire ? gnt_onehot : '0;
      if (fire) begin
        ps_data_q <= tf_ps.tf_dout;
        rr_ptr    <= (gnt_idx == PW'(NUM_PARSER - 1)) ? '0 : gnt_idx + PW'(1);
        if (tok_count != '1)
          tok_count <= tok_count + CNT_W'(1);
      end
      if ((state == IDLE) && start)
        tok_count <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_done   <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            in_done <= page_input_finish;
          end
        end
        RUN: begin
          in_done <= in_done_nxt;
          if (in_done_nxt && tf_ps.tf_empty) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (all_quiet) begin
            drain_cnt <= drain_cnt + 8'd1;
            if (drain_cnt == 8'(DRAIN_CYC - 1))
              state <= DONE;
          end else begin
            drain_cnt <= '0;
          end
        end
        DONE: begin
          if (cl_finish)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] tok_cnt_q [NUM_PARSER];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PARSER; i++) tok_cnt_q[i] <= '0;
      stall_cnt <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        for (int i = 0; i < NUM_PARSER; i++) tok_cnt_q[i] <= '0;
      end else if (fire && (tok_cnt_q[gnt_idx] != 16'hffff)) begin
        tok_cnt_q[gnt_idx] <= tok_cnt_q[gnt_idx] + 16'd1;
      end
      // Tokens waiting but every parser busy or just strobed.
      if ((state == RUN) && !tf_ps.tf_empty && (elig == '0) && (stall_cnt != 16'hffff))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_PARSER; g++) begin : g_cnt
    assign ps_tok_cnt[g*16 +: 16] = tok_cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_token_dispatch.sv
// Self-checking bench for token_dispatch: randomized FIFO/parser stimulus vs a queue-based page model.
// Latency: checks the 1-cycle FIFO-head to ps_valid path every cycle.
// Backpressure: parser readiness and FIFO occupancy are randomized.
module tb_token_dispatch;
  localparam int N  = 6;
  localparam int IW = 3;
  localparam int TW = 144;
  localparam int DC = 16;
  localparam int CW = 32;

  typedef enum {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          page_input_finish;
  logic          cl_finish;
  logic [15:0]   ram_empty;
  logic          page_finish;
  logic          busy;
  logic [CW-1:0] tok_count;
`ifdef DISPATCH_STATS_EN
  logic [N*16-1:0] ps_tok_cnt;
  logic [15:0]     stall_cnt;
`endif

  token_dispatch_if #(.NUM_PARSER(N), .TOKEN_W(TW)) bus ();

  token_dispatch #(.NUM_PARSER(N), .TOKEN_W(TW), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .page_input_finish (page_input_finish),
    .tf_ps             (bus),
    .ram_empty         (ram_empty),
    .cl_finish         (cl_finish),
    .page_finish       (page_finish),
    .busy              (busy),
    .tok_count         (tok_count)
`ifdef DISPATCH_STATS_EN
    ,
    .ps_tok_cnt        (ps_tok_cnt),
    .stall_cnt         (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Token FIFO contents and page model.
  logic [TW-1:0] tq[$];
  phase_t        ph;
  logic [N-1:0]  m_valid;
  logic [TW-1:0] m_data;
  int            m_ptr;
  logic [CW-1:0] m_cnt;
  bit            m_in_done;
  int            m_quiet;
  bit            exp_rd;
  logic          obs_rd;

  function automatic logic [TW-1:0] rand_tok();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW; i += 16) t[i +: 16] = 16'($urandom);
    return t;
  endfunction

  task automatic model_reset();
    ph = P_IDLE; m_valid = '0; m_data = '0; m_ptr = 0;
    m_cnt = '0; m_in_done = 1'b0; m_quiet = 0;
  endtask

  // One clock: present FIFO head, sample the pop strobe, advance the model.
  // Called and returning at posedge+1; pulse inputs are cleared on return.
  task automatic tick();
    logic [N-1:0] elig;
    int  g;
    int  idx;
    bit  fire;
    bit  quiet;
    bit  empty;
    empty = (tq.size() == 0);
    bus.tf_empty = empty;
    bus.tf_dout  = empty ? rand_tok() : tq[0];
    #1;
    elig = bus.ps_ready & ~m_valid;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && elig[IW'(idx)]) g = idx;
    end
    fire   = (ph == P_RUN || ph == P_DRAIN) && !empty && (g >= 0);
    exp_rd = fire;
    obs_rd = bus.tf_rd_en;
    quiet  = (&bus.ps_empty) && (ram_empty == 16'hffff) && empty && (m_valid == '0);
    @(posedge clk);
    case (ph)
      P_IDLE:  if (start) begin ph = P_RUN; m_cnt = '0; m_in_done = page_input_finish; end
      P_RUN: begin
        m_in_done = m_in_done | page_input_finish;
        if (m_in_done && empty) begin ph = P_DRAIN; m_quiet = 0; end
      end
      P_DRAIN: begin
        m_quiet = quiet ? m_quiet + 1 : 0;
        if (m_quiet == DC) ph = P_DONE;
      end
      P_DONE:  if (cl_finish) ph = P_IDLE;
    endcase
    m_valid = '0;
    if (fire) begin
      m_valid[IW'(g)] = 1'b1;
      m_data = tq.pop_front();
      m_ptr = (g + 1) % N;
      if (m_cnt != '1) m_cnt = m_cnt + 1;
    end
    #1;
    start = 1'b0; page_input_finish = 1'b0; cl_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; page_input_finish = 1'b0; cl_finish = 1'b0;
    ram_empty = 16'hffff; bus.ps_ready = '0; bus.ps_empty = '1;
    bus.tf_empty = 1'b1; bus.tf_dout = '0;
    #3;
    checks++; if (bus.ps_valid !== '0) begin errors++; $display("FAIL reset_ps_valid got=%h want=0", bus.ps_valid); end
    checks++; if (bus.ps_data !== '0) begin errors++; $display("FAIL reset_ps_data got=%h want=0", bus.ps_data); end
    checks++; if (bus.tf_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b want=0", bus.tf_rd_en); end
    checks++; if (page_finish !== 1'b0) begin errors++; $display("FAIL reset_page_finish got=%b want=0", page_finish); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (tok_count !== '0) begin errors++; $display("FAIL reset_tok_count got=%0d want=0", tok_count); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    int grants;
    grants = 0;
    start = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy got=%b want=1", busy); end
    bus.ps_ready = '1;
    for (int i = 0; i < 12; i++) tq.push_back(rand_tok());
    for (int c = 0; c < 16; c++) begin
      tick();
      if (obs_rd === 1'b1) grants++;
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rr_rd_en c=%0d got=%b want=%b", c, obs_rd, exp_rd); end
      checks++; if (bus.ps_valid !== m_valid) begin errors++; $display("FAIL rr_ps_valid c=%0d got=%b want=%b", c, bus.ps_valid, m_valid); end
      checks++; if (bus.ps_data !== m_data) begin errors++; $display("FAIL rr_ps_data c=%0d got=%h want=%h", c, bus.ps_data, m_data); end
      if (c == 0) begin
        checks++; if (bus.ps_valid !== 6'b000001) begin errors++; $display("FAIL rr_first_grant got=%b want=000001", bus.ps_valid); end
      end
    end
    checks++; if (tok_count !== 32'd12) begin errors++; $display("FAIL rr_tok_count got=%0d want=12", tok_count); end
    checks++; if (grants != 12) begin errors++; $display("FAIL rr_pops got=%0d want=12", grants); end
  endtask

  task automatic test_masking();
    logic [N-1:0] prev;
    int got;
    prev = '0; got = 0;
    bus.ps_ready = 6'b001000;
    for (int i = 0; i < 6; i++) tq.push_back(rand_tok());
    for (int c = 0; c < 14; c++) begin
      tick();
      if (bus.ps_valid !== '0) got++;
      checks++; if (bus.ps_valid !== m_valid) begin errors++; $display("FAIL mask_ps_valid c=%0d got=%b want=%b", c, bus.ps_valid, m_valid); end
      checks++; if ((bus.ps_valid & prev) !== '0) begin errors++; $display("FAIL mask_consecutive c=%0d got=%b prev=%b want=none", c, bus.ps_valid, prev); end
      prev = bus.ps_valid;
    end
    checks++; if (got != 6) begin errors++; $display("FAIL mask_deliveries got=%0d want=6", got); end
    checks++; if (tok_count !== 32'd18) begin errors++; $display("FAIL mask_tok_count got=%0d want=18", tok_count); end
  endtask

  task automatic test_empty_stall();
    for (int c = 0; c < 20; c++) begin
      bus.ps_ready = N'($urandom);
      if (c == 5) start = 1'b1;      // ignored mid-page
      if (c == 9) cl_finish = 1'b1;  // ignored outside DONE
      tick();
      checks++; if (obs_rd !== 1'b0) begin errors++; $display("FAIL stall_rd_en c=%0d got=%b want=0", c, obs_rd); end
      checks++; if (bus.ps_valid !== '0) begin errors++; $display("FAIL stall_ps_valid c=%0d got=%b want=0", c, bus.ps_valid); end
      checks++; if (busy !== 1'b1 || page_finish !== 1'b0) begin errors++; $display("FAIL stall_state c=%0d busy=%b pf=%b want busy=1 pf=0", c, busy, page_finish); end
      checks++; if (tok_count !== m_cnt || bus.ps_data !== m_data) begin errors++; $display("FAIL stall_hold c=%0d cnt=%0d want=%0d", c, tok_count, m_cnt); end
    end
  endtask

  task automatic test_drain();
    int finish_at;
    finish_at = -1;
    bus.ps_empty = '1; ram_empty = 16'hffff; bus.ps_ready = '1;
    page_input_finish = 1'b1;
    tick();
    for (int t = 1; t <= 40 && finish_at < 0; t++) begin
      ram_empty = (t == 11) ? 16'hfbff : 16'hffff;
      tick();
      checks++; if (page_finish !== (ph == P_DONE)) begin errors++; $display("FAIL drain_pf t=%0d got=%b want=%b", t, page_finish, ph == P_DONE); end
      if (page_finish === 1'b1) finish_at = t;
    end
    checks++; if (finish_at != 27) begin errors++; $display("FAIL drain_finish_cycle got=%0d want=27", finish_at); end
  endtask

  task automatic test_handoff();
    tq.push_back(rand_tok());
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (obs_rd !== 1'b0 || page_finish !== 1'b1) begin errors++; $display("FAIL done_hold c=%0d rd=%b pf=%b want rd=0 pf=1", c, obs_rd, page_finish); end
    end
    cl_finish = 1'b1;
    tick();
    checks++; if (page_finish !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL handoff_idle pf=%b busy=%b want 0 0", page_finish, busy); end
    tick();
    checks++; if (obs_rd !== 1'b0) begin errors++; $display("FAIL idle_rd_en got=%b want=0", obs_rd); end
    start = 1'b1;
    tick();
    checks++; if (tok_count !== '0 || busy !== 1'b1) begin errors++; $display("FAIL restart cnt=%0d busy=%b want 0 1", tok_count, busy); end
    tick();
    checks++; if (obs_rd !== 1'b1 || tok_count !== 32'd1) begin errors++; $display("FAIL restart_first rd=%b cnt=%0d want 1 1", obs_rd, tok_count); end
  endtask

  task automatic test_reset_mid_burst();
    bus.ps_ready = '1;
    for (int i = 0; i < 5; i++) tq.push_back(rand_tok());
    tick();
    tick();
    bus.tf_empty = 1'b0; bus.tf_dout = tq[0];
    rst = 1'b1;
    #1;
    checks++; if (bus.ps_valid !== '0 || bus.ps_data !== '0) begin errors++; $display("FAIL rstmid_ps valid=%b data=%h want 0", bus.ps_valid, bus.ps_data); end
    checks++; if (bus.tf_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got=%b want=0", bus.tf_rd_en); end
    checks++; if (tok_count !== '0 || busy !== 1'b0 || page_finish !== 1'b0) begin errors++; $display("FAIL rstmid_status cnt=%0d busy=%b pf=%b want 0", tok_count, busy, page_finish); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    bus.ps_ready = 6'b110100;
    start = 1'b1;
    tick();
    tick();
    checks++; if (bus.ps_valid !== 6'b000100) begin errors++; $display("FAIL rstmid_first_grant got=%b want=000100", bus.ps_valid); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (bus.ps_valid !== m_valid || obs_rd !== exp_rd) begin errors++; $display("FAIL rstmid_tail c=%0d valid=%b want=%b", c, bus.ps_valid, m_valid); end
    end
  endtask

  task automatic test_random();
    bit calm;
    for (int c = 0; c < 800; c++) begin
      calm = (c % 100) >= 60;
      bus.ps_ready = N'($urandom);
      bus.ps_empty = (calm || $urandom_range(0, 3) != 0) ? '1 : N'($urandom);
      ram_empty    = (calm || $urandom_range(0, 7) != 0) ? 16'hffff : 16'($urandom);
      if (!calm && tq.size() < 8 && $urandom_range(0, 2) == 0) tq.push_back(rand_tok());
      if (calm && $urandom_range(0, 40) == 0) tq.push_back(rand_tok());
      start             = ($urandom_range(0, 19) == 0);
      page_input_finish = ($urandom_range(0, 29) == 0);
      cl_finish         = ($urandom_range(0, 9) == 0);
      tick();
      checks++; if (obs_rd !== exp_rd) begin errors++; $display("FAIL rand_rd_en c=%0d got=%b want=%b", c, obs_rd, exp_rd); end
      checks++; if (bus.ps_valid !== m_valid) begin errors++; $display("FAIL rand_ps_valid c=%0d got=%b want=%b", c, bus.ps_valid, m_valid); end
      checks++; if (bus.ps_data !== m_data) begin errors++; $display("FAIL rand_ps_data c=%0d got=%h want=%h", c, bus.ps_data, m_data); end
      checks++; if (tok_count !== m_cnt) begin errors++; $display("FAIL rand_tok_count c=%0d got=%0d want=%0d", c, tok_count, m_cnt); end
      checks++; if (page_finish !== (ph == P_DONE)) begin errors++; $display("FAIL rand_page_finish c=%0d got=%b want=%b", c, page_finish, ph == P_DONE); end
      checks++; if (busy !== (ph != P_IDLE)) begin errors++; $display("FAIL rand_busy c=%0d got=%b want=%b", c, busy, ph != P_IDLE); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_masking();
    test_empty_stall();
    test_drain();
    test_handoff();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
